// File: rtl/mult_seq_decomp.sv
// mult_seq_decomp: sequential digit-decomposed multiplier, one SUB_W x SUB_W partial product per cycle.
// Define MULT_SEQ_SIGNED_EN to add the sgn port for two's-complement operands.
module mult_seq_decomp #(
  parameter int WIDTH = 8,
  parameter int SUB_W = 4
) (
  input  logic               clk,
  input  logic               rst_n,
  input  logic               in_valid,
  output logic               in_ready,
  input  logic [WIDTH-1:0]   A,
  input  logic [WIDTH-1:0]   B,
`ifdef MULT_SEQ_SIGNED_EN
  input  logic               sgn,
`endif
  output logic               out_valid,
  input  logic               out_ready,
  output logic [2*WIDTH-1:0] P,
  output logic               busy
);
  localparam int N = WIDTH / SUB_W;
  localparam int IW = N > 1 ? $clog2(N) : 1;
  localparam logic [IW-1:0] LAST = IW'(N - 1);
  typedef enum logic [1:0] {IDLE, CALC, DONE} state_t;
  state_t state_q;
  logic [WIDTH-1:0] a_q, b_q, a_d, b_d;
  logic [IW-1:0] i_q, j_q;
  logic [2*WIDTH-1:0] acc_q, acc_d, p_d, p_q;
  logic [SUB_W-1:0] a_dig, b_dig;
  logic [2*SUB_W-1:0] prod;
  logic in_ready_q, out_valid_q, busy_q;
`ifdef MULT_SEQ_SIGNED_EN
  logic neg_q, neg_d;
`endif
  always_comb begin
    a_dig = SUB_W'(a_q >> (SUB_W * int'(i_q)));
    b_dig = SUB_W'(b_q >> (SUB_W * int'(j_q)));
    prod = a_dig * b_dig;
    acc_d = acc_q + ((2*WIDTH)'(prod) << (SUB_W * (int'(i_q) + int'(j_q))));
`ifdef MULT_SEQ_SIGNED_EN
    // magnitudes are multiplied; the sign is reapplied when the result is loaded
    a_d = (sgn && A[WIDTH-1]) ? -A : A;
    b_d = (sgn && B[WIDTH-1]) ? -B : B;
    neg_d = sgn && (A[WIDTH-1] ^ B[WIDTH-1]);
    p_d = neg_q ? -acc_d : acc_d;
`else
    a_d = A;
    b_d = B;
    p_d = acc_d;
`endif
  end
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= IDLE;
      a_q <= '0;
      b_q <= '0;
      i_q <= '0;
      j_q <= '0;
      acc_q <= '0;
      p_q <= '0;
      in_ready_q <= 1'b0;
      out_valid_q <= 1'b0;
      busy_q <= 1'b0;
`ifdef MULT_SEQ_SIGNED_EN
      neg_q <= 1'b0;
`endif
    end else begin
      case (state_q)
        IDLE: begin
          if (in_valid && in_ready_q) begin
            state_q <= CALC;
            a_q <= a_d;
            b_q <= b_d;
            i_q <= '0;
            j_q <= '0;
            acc_q <= '0;
            in_ready_q <= 1'b0;
            busy_q <= 1'b1;
`ifdef MULT_SEQ_SIGNED_EN
            neg_q <= neg_d;
`endif
          end else begin
            in_ready_q <= 1'b1;
          end
        end
        CALC: begin
          acc_q <= acc_d;
          if (i_q == LAST && j_q == LAST) begin
            state_q <= DONE;
            p_q <= p_d;
            out_valid_q <= 1'b1;
          end else if (j_q == LAST) begin
            j_q <= '0;
            i_q <= i_q + IW'(1);
          end else begin
            j_q <= j_q + IW'(1);
          end
        end
        DONE: begin
          if (out_ready) begin
            state_q <= IDLE;
            out_valid_q <= 1'b0;
            busy_q <= 1'b0;
            in_ready_q <= 1'b1;
          end
        end
        default: state_q <= IDLE;
      endcase
    end
  end
  assign in_ready = in_ready_q;
  assign out_valid = out_valid_q;
  assign busy = busy_q;
  assign P = p_q;
endmodule

// File: doc/mult_seq_decomp.md
# mult_seq_decomp

Parametrised, time-multiplexed unsigned multiplier that splits WIDTH-bit operands into SUB_W-bit digits and accumulates all digit cross-products through one shared SUB_W×SUB_W sub-multiplier, one partial product per cycle. It is the sequential successor of the fixed 8-bit, four-sub-multiplier decomposition: the same partial-product arithmetic, but in one quarter of the multiplier area, with valid/ready handshakes on both sides. It sits between operand producers and result consumers in the multiplier datapath.

## Interface
- WIDTH, 8, operand width; must be a multiple of SUB_W.
- SUB_W, 4, digit width of the shared sub-multiplier.
- clk  in  1  clock; all logic is rising-edge.
- rst_n  in  1  asynchronous active-low reset.
- in_valid  in  1  operands valid.
- in_ready  out  1  block can accept operands.
- A  in  WIDTH  multiplicand.
- B  in  WIDTH  multiplier.
- out_valid  out  1  result valid.
- out_ready  in  1  consumer accepts result.
- P  out  2*WIDTH  product, registered.
- busy  out  1  high in CALC or DONE.
- sgn  in  1  only present with MULT_SEQ_SIGNED_EN; operands are two's complement when 1.

## Operation
- N = WIDTH/SUB_W digits per operand; K = N*N partial products.
- FSM states: IDLE, CALC, DONE. Reset state is IDLE.
- IDLE: in_ready=1. On in_valid&&in_ready, latch A and B, clear the 2*WIDTH accumulator, set digit indices i=0 and j=0, and go to CALC.
- CALC: each cycle, acc += (A[i digit] * B[j digit]) << ((i+j)*SUB_W). The sub-product is combinational, and the add is done at 2*WIDTH bits with carries discarded above that width, which can never happen because the full product fits. j is the inner index, i the outer. After the (N-1,N-1) term, go to DONE and load P from the final sum.
- DONE: out_valid=1 and P is held stable. On out_ready, go to IDLE. The result must not change while out_ready is low.
- in_valid in CALC or DONE is ignored, because in_ready=0. Operands are not re-sampled.
- Reset values: in_ready=0 while rst_n is low and 1 in IDLE after reset; out_valid=0, P=0, busy=0. The accumulator and indices are 0.
- An asynchronous reset during CALC or DONE aborts the operation immediately. No out_valid is produced for the aborted operands.

## Timing
- Define the acceptance edge as T. The CALC updates occur on edges T+1 through T+K. out_valid rises after edge T+K, so latency is K cycles.
- The DONE→IDLE transition occurs on the first edge where out_ready=1. in_ready is 1 on the following cycle.
- Minimum issue interval is K+2 cycles, with out_ready held high.
- For WIDTH=8 and SUB_W=4: K=4, latency 4, interval 6.
- out_valid and in_ready are never high in the same cycle.

## Configuration
- MULT_SEQ_SIGNED_EN defined:
  - Adds the sgn port, which is sampled on acceptance.
  - With sgn=1: latch |A| and |B| as WIDTH-bit unsigned values (|−2^(WIDTH−1)| = 2^(WIDTH−1) is representable), and store neg = A[MSB]^B[MSB].
  - On the CALC→DONE edge, P = neg ? −acc : acc, truncated to 2*WIDTH bits. Latency is unchanged.
  - With sgn=0, behaviour is identical to the unsigned build.
- MULT_SEQ_SIGNED_EN undefined: there is no sgn port, all operands are unsigned, and there is no negation logic.

## Test plan
- Unsigned corner values (WIDTH=8, SUB_W=4): A=255, B=255 → P=65025 (0xFE01) with out_valid exactly 4 cycles after acceptance. A=0, B=200 → P=0. A=1, B=1 → P=1.
- Back-pressure: accept A=13, B=11 and hold out_ready=0 for 5 cycles → P=143 stays stable with out_valid=1 and in_ready=0. A new in_valid in that window is ignored. Releasing out_ready gives in_ready=1 on the next cycle.
- Back-to-back: out_ready=1 and in_valid held with (200,3) then (17,17) → P=600 then 289, with acceptances 6 cycles apart.
- Reset mid-CALC: accept (99,99) and drop rst_n 2 cycles later → out_valid=0 and P=0 immediately. After release, (5,6) → P=30 with no stale 9801.
- Signed build with sgn=1: (−128)×(−128) → 16384 (0x4000). (−3)×5 → 0xFFF1. 127×(−1) → 0xFF81. The same (−3, 5) bit patterns (253, 5) with sgn=0 → 1265.
- Scaled build (WIDTH=16, SUB_W=4): 65535×65535 → 0xFFFE0001 with latency 16 cycles. 0x1234×0x0010 → 0x00012340.
